ipm_mcu_host: RTL and testbench
===============================

# ipm_mcu_host

Bus-master counterpart of the MCU-side ipm port. It converts 32-bit word commands from an on-chip controller or testbench driver into byte-wide address/read/write strobe sequences on the 8-bit MCU bus. It also waits on the ipm interrupt line. The block sits where the external MCU would, driving `addressMCU`/`rdMCU`/`wrMCU`/`dataMCU` of an ipm-wrapped IP such as the convolution processor.

## Interface
- `STROBE_CYCLES`, default 2: cycles `rdMCU`/`wrMCU` stay high per access (≥1).
- `TIMEOUT`, default 1024: maximum cycles spent waiting for `intMCU` after START. 0 means wait forever.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_op` in 2: 00 WRITE, 01 READ, 10 START, 11 STATUS.
- `cmd_conf` in 5: configuration value written before WRITE/READ/START.
- `cmd_data` in 32: word for WRITE.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_data` out 32: READ word, or `{24'b0,status}` for START/STATUS. 0 for WRITE.
- `rsp_err` out 1: START timed out. Valid with `rsp_valid`.
- `addressMCU` out 4: bus address.
- `rdMCU` out 1: read strobe, active-high.
- `wrMCU` out 1: write strobe, active-high.
- `dataMCU_o` out 8: write data.
- `dataMCU_oe` out 1: tristate enable. The top level builds the inout from this.
- `dataMCU_i` in 8: bus read data.
- `intMCU` in 1: interrupt from ipm, level.

## Operation
- Bus map:
  - addresses 0–3: data bytes, LSB first.
  - address 4: conf (bits 4:0).
  - address 5: control (bit0 WRITE, bit1 READ, bit2 START).
  - address 6: status. Reading it clears the interrupt.
- Command sequences (accesses in order):
  - WRITE: wr(4,conf), wr(0..3,data bytes), wr(5,0x01). 6 accesses.
  - READ: wr(4,conf), wr(5,0x02), rd(0..3). Bytes assemble LSB first. 6 accesses.
  - START: wr(4,conf), wr(5,0x04), WAIT_INT, rd(6). On timeout the rd(6) is skipped, `rsp_err`=1 and `rsp_data`=0.
  - STATUS: rd(6). 1 access.
- FSM states: IDLE → SETUP → STROBE → HOLD → (next access: SETUP | WAIT_INT | RESP).
  - WAIT_INT → SETUP when `intMCU`=1, or → RESP on timeout.
  - RESP → IDLE.
  - An access-step counter (0..5) selects address and data.
- Reset values: `cmd_ready`=1. `rsp_valid`, `rsp_err`, `rdMCU`, `wrMCU`, `dataMCU_oe` = 0. `addressMCU`, `dataMCU_o`, `rsp_data` = 0. State is IDLE.
- `cmd_valid` is ignored outside IDLE. Commands are never queued.
- `rst` asserted mid-command: at the next edge all outputs take reset values, the command is dropped and no `rsp_valid` is produced.

## Timing
- Acceptance: `cmd_valid & cmd_ready` at edge E0. The first SETUP occupies the cycle after E0.
- One access lasts `STROBE_CYCLES`+2 cycles:
  - SETUP: address and data valid, `dataMCU_oe` high for writes, strobes low.
  - STROBE: strobe high for `STROBE_CYCLES` cycles.
  - HOLD: strobe low, address and data unchanged.
- Read data is sampled at the edge ending the last STROBE cycle.
- `dataMCU_oe` is high only during SETUP/STROBE/HOLD of write accesses. It is low in every other cycle, which gives read turnaround.
- Accesses are back-to-back, with no idle cycle between HOLD and the next SETUP.
- `rsp_valid` is high in the RESP cycle, N·(`STROBE_CYCLES`+2)+1 cycles after E0, plus any WAIT_INT cycles.
- `cmd_ready` returns high the cycle after RESP.
- WAIT_INT:
  - `intMCU` is sampled each cycle starting with the cycle after the control-write HOLD.
  - If `intMCU` is already high, exactly one WAIT_INT cycle is spent.
  - Timeout fires after `TIMEOUT` WAIT_INT cycles with `intMCU` low.

## Structure
- Package `ipm_host_pkg` holds:
  - op codes;
  - address constants DATA0..3, CONF, CTRL, STATUS;
  - control bit constants CTRL_WRITE, CTRL_READ, CTRL_START.
- Sub-module `ipm_host_bus_cycle` is a single-byte access engine:
  - inputs: go, rnw, addr, wdata; outputs: done, rdata;
  - it owns the SETUP/STROBE/HOLD timing and strobe outputs.
- The top level owns command sequencing, WAIT_INT and the response.

## Test plan
- **WRITE:** conf=5'h03, data=32'hDEADBEEF, default parameters → bus writes (4,03), (0,EF), (1,BE), (2,AD), (3,DE), (5,01). Each strobe is 2 cycles high. `rsp_valid` 25 cycles after acceptance, `rsp_err`=0.
- **READ:** bus model returns 78, 56, 34, 12 at addresses 0..3 → `rsp_data`=32'h12345678 at cycle 25. `dataMCU_oe`=0 during all four reads.
- **START with interrupt:** `intMCU` rises 10 cycles after the control-write HOLD, status byte 0x01 → rd(6) is issued and `rsp_data`=1, `rsp_err`=0.
- **START timeout:** `TIMEOUT`=16, `intMCU` held 0 → no rd(6). `rsp_valid` at cycle 8+16+1=25 after acceptance, with `rsp_err`=1 and `rsp_data`=0.
- **Reset mid-READ:** `rst` for one cycle at cycle 7 → next cycle strobes=0, `oe`=0, `cmd_ready`=1. No `rsp_valid` ever appears for that command.
- **Back-to-back:** `cmd_valid` held high with STATUS, then WRITE → second command accepted the cycle after the first RESP. No bus activity overlaps.

Source files
------------

// File: rtl/ipm_host_pkg.sv
// ipm_host_pkg: shared definitions for the ipm MCU-side bus master.
// Holds command op codes, the ipm bus address map, control-register bits,
// FSM state types and the per-step access decoder used by ipm_mcu_host.
package ipm_host_pkg;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'b00,
    OP_READ   = 2'b01,
    OP_START  = 2'b10,
    OP_STATUS = 2'b11
  } op_e;

  localparam logic [3:0] ADDR_DATA0  = 4'd0;
  localparam logic [3:0] ADDR_DATA1  = 4'd1;
  localparam logic [3:0] ADDR_DATA2  = 4'd2;
  localparam logic [3:0] ADDR_DATA3  = 4'd3;
  localparam logic [3:0] ADDR_CONF   = 4'd4;
  localparam logic [3:0] ADDR_CTRL   = 4'd5;
  localparam logic [3:0] ADDR_STATUS = 4'd6;

  localparam logic [7:0] CTRL_WRITE = 8'h01;
  localparam logic [7:0] CTRL_READ  = 8'h02;
  localparam logic [7:0] CTRL_START = 8'h04;

  typedef struct packed {
    logic       rnw;
    logic [3:0] addr;
    logic [7:0] wdata;
  } access_t;

  typedef enum logic [1:0] {BC_IDLE, BC_SETUP, BC_STROBE, BC_HOLD} bc_state_e;
  typedef enum logic [1:0] {H_IDLE, H_ACCESS, H_WAIT_INT, H_RESP} host_state_e;

  // Bus access issued at a given step of a command. Step 0 is always the
  // conf write except for STATUS, which is a lone status read.
  function automatic access_t access_decode(input op_e op, input logic [2:0] step,
                                            input logic [4:0] conf, input logic [31:0] data);
    access_t    a;
    logic [31:0] sh;
    a.rnw   = 1'b0;
    a.addr  = ADDR_CONF;
    a.wdata = {3'b000, conf};
    sh      = data >> {step - 3'd1, 3'b000};
    case (op)
      OP_WRITE: begin
        if (step >= 3'd1 && step <= 3'd4) begin
          a.addr  = {1'b0, step - 3'd1};
          a.wdata = sh[7:0];
        end else if (step == 3'd5) begin
          a.addr  = ADDR_CTRL;
          a.wdata = CTRL_WRITE;
        end
      end
      OP_READ: begin
        if (step == 3'd1) begin
          a.addr  = ADDR_CTRL;
          a.wdata = CTRL_READ;
        end else if (step >= 3'd2) begin
          a.rnw   = 1'b1;
          a.addr  = {1'b0, step - 3'd2};
          a.wdata = '0;
        end
      end
      OP_START: begin
        if (step == 3'd1) begin
          a.addr  = ADDR_CTRL;
          a.wdata = CTRL_START;
        end else if (step >= 3'd2) begin
          a.rnw   = 1'b1;
          a.addr  = ADDR_STATUS;
          a.wdata = '0;
        end
      end
      OP_STATUS: begin
        a.rnw   = 1'b1;
        a.addr  = ADDR_STATUS;
        a.wdata = '0;
      end
      default: ;
    endcase
    return a;
  endfunction

  function automatic logic [2:0] last_step(input op_e op);
    case (op)
      OP_WRITE, OP_READ: return 3'd5;
      OP_START:          return 3'd2;
      default:           return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/ipm_host_bus_cycle.sv
// ipm_host_bus_cycle: single-byte access engine on the 8-bit MCU bus.
// go_i/rnw_i/addr_i/wdata_i : access request, taken when idle or in HOLD
// done_o                    : high during HOLD (access complete)
// rdata_o                   : byte captured at the end of the last STROBE cycle
// bus_*                     : address, strobes, write data and tristate enable
module ipm_host_bus_cycle
  import ipm_host_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go_i,
  input  logic       rnw_i,
  input  logic [3:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic       done_o,
  output logic [7:0] rdata_o,
  output logic [3:0] bus_addr_o,
  output logic       bus_rd_o,
  output logic       bus_wr_o,
  output logic [7:0] bus_wdata_o,
  output logic       bus_oe_o,
  input  logic [7:0] bus_rdata_i
);

  localparam int unsigned CW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam logic [CW-1:0] SLAST = CW'(STROBE_CYCLES - 1);

  bc_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rnw_q;
  logic [3:0]    addr_q;
  logic [7:0]    wdata_q, rdata_q;
  logic          accept;

  // HOLD accepts a new request so consecutive accesses run back-to-back.
  assign accept = go_i && (state_q == BC_IDLE || state_q == BC_HOLD);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_o  = 1'b0;
    case (state_q)
      BC_IDLE:   if (go_i) state_d = BC_SETUP;
      BC_SETUP: begin
        state_d = BC_STROBE;
        cnt_d   = '0;
      end
      BC_STROBE: begin
        if (cnt_q == SLAST) state_d = BC_HOLD;
        else                cnt_d   = cnt_q + 1'b1;
      end
      BC_HOLD: begin
        done_o  = 1'b1;
        state_d = go_i ? BC_SETUP : BC_IDLE;
      end
      default: state_d = BC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BC_IDLE;
      cnt_q   <= '0;
      rnw_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        rnw_q   <= rnw_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
      end
      if (state_q == BC_STROBE && cnt_q == SLAST && rnw_q) rdata_q <= bus_rdata_i;
    end
  end

  assign rdata_o     = rdata_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign bus_rd_o    = (state_q == BC_STROBE) &&  rnw_q;
  assign bus_wr_o    = (state_q == BC_STROBE) && !rnw_q;
  assign bus_oe_o    = (state_q != BC_IDLE)   && !rnw_q;

endmodule

// File: rtl/ipm_mcu_host.sv
// ipm_mcu_host: bus master standing in for the external MCU of an ipm port.
// cmd_*      : 32-bit command request (WRITE/READ/START/STATUS), ready only in IDLE
// rsp_*      : one-cycle completion pulse with read word / status / timeout flag
// *MCU       : 8-bit MCU bus (address, strobes, split data with tristate enable)
// intMCU     : level interrupt from the ipm, awaited after START
module ipm_mcu_host
  import ipm_host_pkg::*;
#(
  parameter int unsigned STROBE_CYCLES = 2,
  parameter int unsigned TIMEOUT       = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_conf,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [3:0]  addressMCU,
  output logic        rdMCU,
  output logic        wrMCU,
  output logic [7:0]  dataMCU_o,
  output logic        dataMCU_oe,
  input  logic [7:0]  dataMCU_i,
  input  logic        intMCU
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  host_state_e state_q, state_d;
  op_e         op_q, op_d;
  logic [4:0]  conf_q, conf_d;
  logic [31:0] cdata_q, cdata_d;
  logic [2:0]  step_q, step_d, issue_step;
  logic [TW-1:0] wcnt_q, wcnt_d;
  logic [31:0] rsp_q, rsp_d;
  logic        err_q, err_d;
  logic        go, bc_done;
  logic [7:0]  bc_rdata;
  access_t     nxt;

  // In IDLE the first access is decoded straight from the command inputs so
  // SETUP can begin in the cycle right after acceptance.
  always_comb begin
    issue_step = (state_q == H_IDLE) ? 3'd0 : step_q + 3'd1;
    if (state_q == H_IDLE) nxt = access_decode(op_e'(cmd_op), issue_step, cmd_conf, cmd_data);
    else                   nxt = access_decode(op_q, issue_step, conf_q, cdata_q);
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    conf_d  = conf_q;
    cdata_d = cdata_q;
    step_d  = step_q;
    wcnt_d  = wcnt_q;
    rsp_d   = rsp_q;
    err_d   = err_q;
    go      = 1'b0;
    case (state_q)
      H_IDLE: begin
        if (cmd_valid) begin
          go      = 1'b1;
          op_d    = op_e'(cmd_op);
          conf_d  = cmd_conf;
          cdata_d = cmd_data;
          step_d  = '0;
          rsp_d   = '0;
          err_d   = 1'b0;
          state_d = H_ACCESS;
        end
      end
      H_ACCESS: begin
        if (bc_done) begin
          // Status reads replace the response; data reads shift in LSB first.
          if (addressMCU == ADDR_STATUS)              rsp_d = {24'b0, bc_rdata};
          else if (op_q == OP_READ && step_q >= 3'd2) rsp_d = {bc_rdata, rsp_q[31:8]};
          if (step_q == last_step(op_q)) begin
            state_d = H_RESP;
          end else if (op_q == OP_START && step_q == 3'd1) begin
            wcnt_d  = '0;
            state_d = H_WAIT_INT;
          end else begin
            go     = 1'b1;
            step_d = issue_step;
          end
        end
      end
      H_WAIT_INT: begin
        if (intMCU) begin
          go      = 1'b1;
          step_d  = issue_step;
          state_d = H_ACCESS;
        end else if (TIMEOUT != 0 && wcnt_q == TLAST) begin
          err_d   = 1'b1;
          state_d = H_RESP;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      H_RESP:  state_d = H_IDLE;
      default: state_d = H_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= H_IDLE;
      op_q    <= OP_WRITE;
      conf_q  <= '0;
      cdata_q <= '0;
      step_q  <= '0;
      wcnt_q  <= '0;
      rsp_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      conf_q  <= conf_d;
      cdata_q <= cdata_d;
      step_q  <= step_d;
      wcnt_q  <= wcnt_d;
      rsp_q   <= rsp_d;
      err_q   <= err_d;
    end
  end

  ipm_host_bus_cycle #(.STROBE_CYCLES(STROBE_CYCLES)) u_bus (
    .clk         (clk),
    .rst         (rst),
    .go_i        (go),
    .rnw_i       (nxt.rnw),
    .addr_i      (nxt.addr),
    .wdata_i     (nxt.wdata),
    .done_o      (bc_done),
    .rdata_o     (bc_rdata),
    .bus_addr_o  (addressMCU),
    .bus_rd_o    (rdMCU),
    .bus_wr_o    (wrMCU),
    .bus_wdata_o (dataMCU_o),
    .bus_oe_o    (dataMCU_oe),
    .bus_rdata_i (dataMCU_i)
  );

  assign cmd_ready = (state_q == H_IDLE);
  assign rsp_valid = (state_q == H_RESP);
  assign rsp_err   = (state_q == H_RESP) && err_q;
  assign rsp_data  = rsp_q;

endmodule

// File: tb/tb_ipm_mcu_host.sv
module tb_ipm_mcu_host;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_conf;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [3:0]  addressMCU;
  logic        rdMCU, wrMCU;
  logic [7:0]  dataMCU_o;
  logic        dataMCU_oe;
  logic [7:0]  dataMCU_i;
  logic        intMCU;

  logic [7:0]  bus_mem [16];

  typedef struct packed {
    logic       rnw;
    logic [3:0] addr;
    logic [7:0] data;
  } acc_t;
  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  acc_t exp_acc[$];
  rsp_t exp_rsp[$];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign dataMCU_i = bus_mem[addressMCU];

  ipm_mcu_host #(.STROBE_CYCLES(2), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_conf   (cmd_conf),
    .cmd_data   (cmd_data),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .addressMCU (addressMCU),
    .rdMCU      (rdMCU),
    .wrMCU      (wrMCU),
    .dataMCU_o  (dataMCU_o),
    .dataMCU_oe (dataMCU_oe),
    .dataMCU_i  (dataMCU_i),
    .intMCU     (intMCU)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_acc(input logic rnw, input logic [3:0] addr, input logic [7:0] d);
    exp_acc.push_back('{rnw, addr, d});
  endtask

  task automatic push_rsp(input logic [31:0] d, input logic e);
    exp_rsp.push_back('{d, e});
  endtask

  task automatic push_write(input logic [4:0] conf, input logic [31:0] d);
    push_acc(1'b0, 4'd4, {3'b000, conf});
    push_acc(1'b0, 4'd0, d[7:0]);
    push_acc(1'b0, 4'd1, d[15:8]);
    push_acc(1'b0, 4'd2, d[23:16]);
    push_acc(1'b0, 4'd3, d[31:24]);
    push_acc(1'b0, 4'd5, 8'h01);
  endtask

  // Bus scoreboard: each strobe start pops one expected access.
  initial begin : bus_monitor
    acc_t a;
    logic prev_strb;
    int   strb_len;
    prev_strb = 1'b0;
    strb_len  = 0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        prev_strb = 1'b0;
        strb_len  = 0;
      end else begin
        if ((rdMCU || wrMCU) && !prev_strb) begin
          if (exp_acc.size() == 0) begin
            chk("bus_acc_pending", 32'(exp_acc.size() != 0), 32'd1);
          end else begin
            a = exp_acc.pop_front();
            chk("bus_acc", {17'b0, rdMCU, wrMCU, addressMCU, (wrMCU ? dataMCU_o : 8'h00), dataMCU_oe},
                {17'b0, a.rnw, !a.rnw, a.addr, (a.rnw ? 8'h00 : a.data), !a.rnw});
          end
          strb_len = 0;
        end
        if (rdMCU || wrMCU) begin
          strb_len++;
          chk("bus_overlap_idle", {30'b0, rsp_valid, cmd_ready}, 32'd0);
        end
        if (!(rdMCU || wrMCU) && prev_strb) chk("strobe_len", strb_len, 32'd2);
        prev_strb = rdMCU || wrMCU;
      end
    end
  end

  initial begin : rsp_monitor
    rsp_t r;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && rsp_valid === 1'b1) begin
        if (exp_rsp.size() == 0) begin
          chk("rsp_pending", 32'(exp_rsp.size() != 0), 32'd1);
        end else begin
          r = exp_rsp.pop_front();
          chk("rsp_data", rsp_data, r.data);
          chk("rsp_err", {31'b0, rsp_err}, {31'b0, r.err});
        end
      end
    end
  end

  // Cycle 1 is the cycle following the accepting edge; int_at raises intMCU
  // from that cycle onward (0 = never).
  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [4:0] conf,
                         input logic [31:0] d, input int int_at, input int exp_lat);
    int n;
    @(negedge clk);
    chk({tag, "_ready"}, {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_conf  = conf;
    cmd_data  = d;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    n = 1;
    if (int_at == 1) intMCU = 1'b1;
    while (rsp_valid !== 1'b1 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (n == int_at) intMCU = 1'b1;
    end
    chk({tag, "_latency"}, n, exp_lat);
    @(negedge clk);
    intMCU = 1'b0;
    chk({tag, "_acc_drained"}, 32'(exp_acc.size()), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

  initial begin : main
    int n;
    logic seen;
    for (int unsigned i = 0; i < 16; i++) bus_mem[i] = 8'h00;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_conf  = '0;
    cmd_data  = '0;
    intMCU    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_strobes", {30'b0, rdMCU, wrMCU}, 32'd0);
    chk("rst_oe", {31'b0, dataMCU_oe}, 32'd0);
    chk("rst_addr", {28'b0, addressMCU}, 32'd0);
    chk("rst_dout", {24'b0, dataMCU_o}, 32'd0);
    rst = 1'b0;

    // WRITE
    push_write(5'h03, 32'hDEADBEEF);
    push_rsp(32'd0, 1'b0);
    run_cmd("write", 2'b00, 5'h03, 32'hDEADBEEF, 0, 25);

    // READ, bytes assembled LSB first
    bus_mem[0] = 8'h78; bus_mem[1] = 8'h56; bus_mem[2] = 8'h34; bus_mem[3] = 8'h12;
    push_acc(1'b0, 4'd4, 8'h0A);
    push_acc(1'b0, 4'd5, 8'h02);
    for (int unsigned i = 0; i < 4; i++) push_acc(1'b1, 4'(i), 8'h00);
    push_rsp(32'h12345678, 1'b0);
    run_cmd("read", 2'b01, 5'h0A, 32'hFFFF_FFFF, 0, 25);

    // START, interrupt 10 cycles after control-write HOLD (cycle 8)
    bus_mem[6] = 8'h01;
    push_acc(1'b0, 4'd4, 8'h01);
    push_acc(1'b0, 4'd5, 8'h04);
    push_acc(1'b1, 4'd6, 8'h00);
    push_rsp(32'h1, 1'b0);
    run_cmd("start_int", 2'b10, 5'h01, 32'h0, 18, 23);

    // START with interrupt already high: one WAIT_INT cycle
    bus_mem[6] = 8'h05;
    push_acc(1'b0, 4'd4, 8'h1F);
    push_acc(1'b0, 4'd5, 8'h04);
    push_acc(1'b1, 4'd6, 8'h00);
    push_rsp(32'h5, 1'b0);
    run_cmd("start_int_early", 2'b10, 5'h1F, 32'h0, 1, 14);

    // START timeout: no status read
    push_acc(1'b0, 4'd4, 8'h02);
    push_acc(1'b0, 4'd5, 8'h04);
    push_rsp(32'h0, 1'b1);
    run_cmd("start_timeout", 2'b10, 5'h02, 32'h0, 0, 25);

    // STATUS
    bus_mem[6] = 8'h5A;
    push_acc(1'b1, 4'd6, 8'h00);
    push_rsp(32'h5A, 1'b0);
    run_cmd("status", 2'b11, 5'h00, 32'h0, 0, 5);

    // Reset mid-READ at cycle 7 (strobe of the control write)
    push_acc(1'b0, 4'd4, 8'h07);
    push_acc(1'b0, 4'd5, 8'h02);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_conf = 5'h07;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    n = 1;
    while (n < 7) begin
      @(posedge clk);
      #1;
      n++;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rstmid_strobes", {30'b0, rdMCU, wrMCU}, 32'd0);
    chk("rstmid_oe", {31'b0, dataMCU_oe}, 32'd0);
    chk("rstmid_ready", {31'b0, cmd_ready}, 32'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      seen = seen | (rsp_valid === 1'b1);
    end
    chk("rstmid_no_rsp", {31'b0, seen}, 32'd0);
    chk("rstmid_acc_drained", 32'(exp_acc.size()), 32'd0);

    // Back-to-back: STATUS then WRITE with cmd_valid held high
    bus_mem[6] = 8'h3C;
    push_acc(1'b1, 4'd6, 8'h00);
    push_rsp(32'h3C, 1'b0);
    push_write(5'h11, 32'hA5C30F96);
    push_rsp(32'h0, 1'b0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b11; cmd_conf = 5'h00; cmd_data = 32'h0;
    @(posedge clk);
    #1;
    cmd_op = 2'b00; cmd_conf = 5'h11; cmd_data = 32'hA5C30F96;
    n = 1;
    while (rsp_valid !== 1'b1 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b2b_first_latency", n, 32'd5);
    @(posedge clk);
    #1;
    chk("b2b_idle_ready", {31'b0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("b2b_second_accepted", {31'b0, cmd_ready}, 32'd0);
    cmd_valid = 1'b0;
    n = 1;
    while (rsp_valid !== 1'b1 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b2b_second_latency", n, 32'd25);
    @(negedge clk);
    chk("b2b_acc_drained", 32'(exp_acc.size()), 32'd0);
    chk("rsp_drained", 32'(exp_rsp.size()), 32'd0);

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
